// File: rtl/pulse_train_tx_pkg.sv
// rtl/pulse_train_tx_pkg.sv - shared state encoding, default widths and clock rate for pulse_train_tx
package pulse_train_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int CNT_W_DEF   = 32;
  localparam int BURST_W_DEF = 16;
  localparam int CLK_HZ      = 48000000;

endpackage

// File: rtl/pulse_train_phase_ctr.sv
// rtl/pulse_train_phase_ctr.sv - loadable down-counter timing one HIGH or LOW phase
// o_terminal marks the last cycle of the phase (count==1); the counter parks at 0 instead of wrapping.
module pulse_train_phase_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_terminal = (r_count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pulse_train_tx.sv
// rtl/pulse_train_tx.sv - programmable burst pulse-train transmitter (IDLE/HIGH/LOW)
// Optional unbounded bursts (cmd_count==0) when PULSE_TRAIN_TX_CONTINUOUS_EN is defined.
module pulse_train_tx
  import pulse_train_tx_pkg::*;
#(
  parameter int   CNT_W      = CNT_W_DEF,
  parameter int   BURST_W    = BURST_W_DEF,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk48,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   cmd_period,
  input  logic [CNT_W-1:0]   cmd_high,
  input  logic [BURST_W-1:0] cmd_count,
  input  logic               abort,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BURST_W-1:0] pulses_sent
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_high;
  logic [BURST_W-1:0] r_count;
  logic [BURST_W-1:0] r_pulses_sent;
  logic [BURST_W-1:0] w_sent_nxt;
  logic [BURST_W-1:0] w_sent_inc;
  logic               r_pulse_out;
  logic               r_done;
  logic               r_err;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic               w_latch;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_en;
  logic               w_term;
  logic               w_cmd_bad;
  logic               w_unbounded;

`ifdef PULSE_TRAIN_TX_CONTINUOUS_EN
  assign w_cmd_bad   = (cmd_period == '0) || (cmd_high == '0) || (cmd_high >= cmd_period);
  assign w_unbounded = (r_count == '0);
`else
  assign w_cmd_bad   = (cmd_period == '0) || (cmd_high == '0) || (cmd_high >= cmd_period) ||
                       (cmd_count == '0);
  assign w_unbounded = 1'b0;
`endif

  // Saturating so unbounded bursts cannot roll the count back to zero.
  assign w_sent_inc = (&r_pulses_sent) ? r_pulses_sent : r_pulses_sent + 1'b1;

  pulse_train_phase_ctr #(.CNT_W(CNT_W)) u_phase_ctr (
    .i_clk      (clk48),
    .i_rst_n    (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_terminal (w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sent_nxt  = r_pulses_sent;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (w_cmd_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_sent_nxt  = '0;
            w_state_nxt = HIGH;
            w_load      = 1'b1;
            w_load_val  = cmd_high;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_term) begin
          w_state_nxt = LOW;
          w_load      = 1'b1;
          w_load_val  = r_period - r_high;
        end else begin
          w_en = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_term) begin
          w_sent_nxt = w_sent_inc;
          if (w_unbounded || (w_sent_inc < r_count)) begin
            w_state_nxt = HIGH;
            w_load      = 1'b1;
            w_load_val  = r_high;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_period      <= '0;
      r_high        <= '0;
      r_count       <= '0;
      r_pulses_sent <= '0;
      r_pulse_out   <= IDLE_LEVEL;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pulses_sent <= w_sent_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      if (w_latch) begin
        r_period <= cmd_period;
        r_high   <= cmd_high;
        r_count  <= cmd_count;
      end
      // Output is driven from the next state so it lines up with the state it describes.
      case (w_state_nxt)
        HIGH:    r_pulse_out <= 1'b1;
        LOW:     r_pulse_out <= 1'b0;
        default: r_pulse_out <= IDLE_LEVEL;
      endcase
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign pulse_out   = r_pulse_out;
  assign done        = r_done;
  assign err         = r_err;
  assign pulses_sent = r_pulses_sent;

endmodule

// File: doc/pulse_train_tx.md
Name: pulse_train_tx

Overview:
Programmable pulse-train transmitter. It emits bursts of clean, debounce-compatible rectangular pulses on a single output pin (e.g. sda), with a commanded period, high time and pulse count. It is the transmit side of the board's tap-tempo/period-measure input path. Looping its output into the scl input path gives a self-test of period capture and LED playback.

Parameters:
CNT_W, 32, width of period and high-time fields in clk48 cycles
BURST_W, 16, width of pulse count field
IDLE_LEVEL, 0, level driven on pulse_out when not emitting a high phase

Ports:
clk48  in  1  system clock, 48 MHz
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (IDLE only)
cmd_period  in  CNT_W  pulse period in cycles
cmd_high  in  CNT_W  high-phase length in cycles
cmd_count  in  BURST_W  number of pulses in burst
abort  in  1  stop the current burst immediately
pulse_out  out  1  registered pulse output
busy  out  1  burst in progress
done  out  1  one-cycle strobe when a burst completes normally
err  out  1  one-cycle strobe when a command is rejected
pulses_sent  out  BURST_W  pulses completed in the current or last burst

Behaviour:
- All state changes on posedge clk48. rst_n=0 sampled at an edge gives: state IDLE, pulse_out=IDLE_LEVEL, cmd_ready=1, busy=0, done=0, err=0, pulses_sent=0, all counters 0.
- States are IDLE, HIGH and LOW. cmd_ready=1 only in IDLE. A handshake occurs at an edge where cmd_valid&&cmd_ready.
- Command validation at handshake. The command is rejected if any of these holds: cmd_period==0, cmd_high==0, cmd_high>=cmd_period, or cmd_count==0 (see Optional Feature). On rejection, err=1 for the next cycle only, the state stays IDLE and pulses_sent is unchanged.
- Valid command: period, high and count are latched, pulses_sent is cleared, and the state goes to HIGH. pulse_out is high from the cycle after the handshake edge, i.e. latency 1.
- HIGH: pulse_out high for exactly cmd_high cycles, then LOW.
- LOW: pulse_out low for exactly cmd_period-cmd_high cycles. At the end of LOW, pulses_sent increments.
  - If pulses_sent (new value) < count, go to HIGH.
  - Otherwise go to IDLE with done=1 for that one cycle. cmd_ready is 1 in that same cycle.
- Burst duration is exactly count*period cycles from the first high cycle to the done cycle, exclusive.
- pulse_out is IDLE_LEVEL in IDLE and low in LOW. It is always a flop output, so it is glitch-free.
- busy=1 in HIGH and LOW.
- Counters are CNT_W wide and never wrap: the phase counter reloads at each phase boundary. pulses_sent saturates at 2^BURST_W-1. This is only reachable under the Optional Feature.
- abort=1 in HIGH/LOW: next state IDLE, pulse_out=IDLE_LEVEL next cycle, done stays 0, pulses_sent holds its value.
- abort in IDLE is ignored.
- abort and cmd_valid in IDLE in the same cycle: the command is accepted normally, because abort only affects running states.
- rst_n has priority over abort; abort has priority over phase transitions.
- Reset mid-burst: the output returns to IDLE_LEVEL at the next edge with rst_n low, and no done is issued.
- cmd_* inputs are ignored while busy; the latched values are used.

Optional Feature:
PULSE_TRAIN_TX_CONTINUOUS_EN.
- Defined: cmd_count==0 is legal and means an unbounded burst. The block runs until abort or reset and never asserts done. pulses_sent saturates.
- Undefined: cmd_count==0 is rejected with err.

Decomposition:
- Package pulse_train_tx_pkg holds:
  - state enum (IDLE, HIGH, LOW) with 2-bit encoding;
  - default widths CNT_W_DEF=32 and BURST_W_DEF=16;
  - constant CLK_HZ=48000000 for testbench/helper use.
- One sub-module, pulse_train_phase_ctr: a loadable CNT_W down-counter with load, load value, enable and terminal flag (count==1 on the last cycle of a phase). It is used for both HIGH and LOW phases.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high. Required: pulse_out=0, cmd_ready=1, busy=0, pulses_sent=0.
- Basic burst with period=10, high=3, count=4. Required:
  - pulse_out high cycles 1-3, 11-13, 21-23, 31-33 after the handshake;
  - done at cycle 41; pulses_sent=4;
  - cmd_ready=0 from cycle 1 through 40.
- Rejects, each with cmd_valid: period=5/high=5; period=0/high=0; period=8/high=2/count=0 (macro off). Required: err one cycle each, no state change, pulse_out stays 0.
- Abort mid-burst with period=100, high=50, count=3; abort at cycle 130. Required: pulse_out=0 at cycle 131, state IDLE, done never asserted, pulses_sent=1.
- Loopback with period=48000 (1 ms), high=24000, count=5, pulse_out wired to the input of the period-capture path. Required: the captured period equals 48000 cycles, within the debounce window.
- Continuous mode (macro on) with period=4, high=1, count=0; run 1000 cycles, then abort. Required: 250 high cycles observed, done never asserted, pulses_sent=250.
